// File: rtl/wave_display_pkg.sv
// Shared definitions for the waveform display path:
// FSM codes, wave-region bounds and sample RAM geometry.
package wave_display_pkg;

  localparam int RAM_AW  = 9;
  localparam int RAM_DW  = 8;
  localparam int X_BASE  = 512;
  localparam int Y_LIMIT = 512;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_DRAW = 2'b01
  } state_e;

endpackage

// File: rtl/dffr_an.sv
// Plain D register with asynchronous active-low clear to zero.
// Width-parameterised companion of the synchronous dffr.
module dffr_an #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_q <= '0;
    else        o_q <= i_d;
  end

endmodule

// File: rtl/wave_segment_cmp.sv
// Decides whether row value ry lies on the vertical segment
// joining two neighbouring samples (inclusive).
module wave_segment_cmp (
  input  logic [7:0] i_prev,
  input  logic [7:0] i_cur,
  input  logic [7:0] i_ry,
  output logic       o_lit
);

  logic [7:0] w_lo;
  logic [7:0] w_hi;

  assign w_lo  = (i_prev < i_cur) ? i_prev : i_cur;
  assign w_hi  = (i_prev < i_cur) ? i_cur : i_prev;
  assign o_lit = (i_ry >= w_lo) && (i_ry <= w_hi);

endmodule

// File: rtl/wave_display.sv
// Reads the displayed half of the sample RAM per VGA pixel and
// paints the waveform trace inside the 512x512 wave region.
module wave_display
  import wave_display_pkg::*;
#(
  parameter logic [23:0] WAVE_RGB = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB   = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       x,
  input  logic [9:0]        y,
  input  logic              valid,
  input  logic              read_index,
  input  logic [RAM_DW-1:0] read_value,
  output logic [RAM_AW-1:0] read_address,
  output logic              valid_pixel,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              wave_display_idle
);

  state_e     r_state;
  logic       r_frame;
  logic       r_idle;

  logic       w_region;
  logic [7:0] w_col;
  logic       w_unused;

  assign w_region = valid && (x[10:9] == 2'b01) && !y[9];
  assign w_col    = x[8:1];
  assign w_unused = x[0];

  assign read_address      = {r_frame, w_col};
  assign wave_display_idle = r_idle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STATE_IDLE;
      r_frame <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      r_idle <= (r_state == STATE_IDLE);
      unique case (r_state)
        STATE_IDLE: begin
          if (valid && (y == 10'd0)) begin
            r_state <= STATE_DRAW;
            r_frame <= read_index;
          end
        end
        STATE_DRAW: begin
          if (y[9]) r_state <= STATE_IDLE;
        end
        default: r_state <= STATE_IDLE;
      endcase
    end
  end

  logic       r_in_s1;
  logic [7:0] r_ry_s1;
  logic [7:0] r_col_s1;
  logic       r_first_s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_s1    <= 1'b0;
      r_ry_s1    <= 8'd0;
      r_col_s1   <= 8'd0;
      r_first_s1 <= 1'b0;
    end else begin
      r_in_s1    <= w_region && (r_state == STATE_DRAW);
      r_ry_s1    <= y[8:1];
      r_col_s1   <= w_col;
      r_first_s1 <= (w_col == 8'd0);
    end
  end

  logic       r_last_vld;
  logic [7:0] r_col_last;
  logic [7:0] r_prev;
  logic [7:0] r_cur;
  logic       w_new;
  logic [7:0] w_prev;

  // Both pixels of a column must see the previous column's sample,
  // so the first pixel of a new column uses the forwarded value.
  assign w_new = r_in_s1 &&
                 (!r_last_vld || (r_col_s1 != r_col_last));
  assign w_prev = !w_new     ? r_prev :
                  r_first_s1 ? read_value : r_cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_vld <= 1'b0;
      r_col_last <= 8'd0;
      r_prev     <= 8'd0;
      r_cur      <= 8'd0;
    end else begin
      r_last_vld <= r_in_s1;
      r_col_last <= r_col_s1;
      if (w_new) begin
        r_prev <= w_prev;
        r_cur  <= read_value;
      end
    end
  end

  logic        w_seg;
  logic        w_lit;
  logic [23:0] w_rgb;
  logic [23:0] w_rgb_q;

  wave_segment_cmp u_cmp (
    .i_prev (w_prev),
    .i_cur  (read_value),
    .i_ry   (r_ry_s1),
    .o_lit  (w_seg)
  );

  assign w_lit = r_in_s1 && w_seg;
  assign w_rgb = w_lit   ? WAVE_RGB :
                 r_in_s1 ? BG_RGB : 24'h0;

  dffr_an #(.W(25)) u_s2 (
    .clk   (clk),
    .rst_n (reset),
    .i_d   ({r_in_s1, w_rgb}),
    .o_q   ({valid_pixel, w_rgb_q})
  );

  assign {r, g, b} = w_rgb_q;

endmodule

// File: tb/tb_wave_display.sv
// Scoreboard bench for wave_display: sweeps rows against a RAM
// model and compares pixels, idle flag and read addresses.
module tb_wave_display;

  localparam logic [23:0] WAVE = 24'hFFFFFF;
  localparam logic [23:0] BG   = 24'h000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic        valid = 1'b0;
  logic        read_index = 1'b0;
  logic [7:0]  read_value = '0;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;
  logic        wave_display_idle;

  always #5 clk = ~clk;

  wave_display dut (
    .clk               (clk),
    .reset             (reset),
    .x                 (x),
    .y                 (y),
    .valid             (valid),
    .read_index        (read_index),
    .read_value        (read_value),
    .read_address      (read_address),
    .valid_pixel       (valid_pixel),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .wave_display_idle (wave_display_idle)
  );

  logic [7:0] mem [0:511];

  always @(posedge clk) read_value <= mem[read_address];

  typedef struct packed {
    logic        vp;
    logic [23:0] rgb;
    logic        idle;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  bit   m_draw = 0;
  bit   m_frame = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (x=%0d y=%0d)",
               tag, act, exp, x, y);
    end
  endtask

  function automatic bit exp_lit(logic [7:0] col, logic [7:0] ry);
    logic [7:0] c, p, lo, hi;
    c  = mem[{m_frame, col}];
    p  = (col == 8'd0) ? c : mem[{m_frame, col - 8'd1}];
    lo = (p < c) ? p : c;
    hi = (p < c) ? c : p;
    return (ry >= lo) && (ry <= hi);
  endfunction

  task automatic step(int xx, int yy, bit v);
    exp_t e;
    bit   reg_in, in_d, lit;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("vp", valid_pixel, e.vp);
      chk("rgb", {r, g, b}, e.rgb);
      chk("idle", wave_display_idle, e.idle);
    end
    x = 11'(xx);
    y = 10'(yy);
    valid = v;
    #1;
    chk("addr", read_address, {m_frame, x[8:1]});
    reg_in = v && (x[10:9] == 2'b01) && !y[9];
    in_d   = m_draw && reg_in;
    lit    = in_d && exp_lit(x[8:1], y[8:1]);
    if (!m_draw && v && (y == 10'd0)) begin
      m_draw  = 1;
      m_frame = read_index;
    end else if (m_draw && y[9]) begin
      m_draw = 0;
    end
    e.vp   = in_d;
    e.rgb  = lit ? WAVE : (in_d ? BG : 24'h0);
    e.idle = !m_draw;
    q.push_back(e);
  endtask

  task automatic row(int yy, bit v, int x0, int x1, bit spot);
    for (int xx = x0; xx <= x1; xx++) begin
      step(xx, yy, v);
      if (spot && xx == 600) chk("addr600", read_address, 9'h12C);
    end
  endtask

  task automatic full_row(int yy);
    row(yy, 1'b1, 290, 1110, 1'b0);
  endtask

  task automatic hit_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_vp", valid_pixel, 1'b0);
    chk("rst_rgb", {r, g, b}, 24'h0);
    chk("rst_idle", wave_display_idle, 1'b1);
    q.delete();
    m_draw  = 0;
    m_frame = 0;
    repeat (3) @(negedge clk);
    chk("rst_addr", read_address, {1'b0, x[8:1]});
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]       = 8'($urandom_range(0, 255));
      mem[256 + i] = 8'd100;
    end
    mem[256 + 10]  = 8'd20;
    mem[256 + 11]  = 8'd60;
    mem[256 + 0]   = 8'd200;
    mem[256 + 255] = 8'd10;

    x = 11'd600;
    y = 10'd10;
    valid = 1'b1;
    #2;
    hit_reset();
    chk("rst_addr600", read_address, 9'h02C);

    full_row(5);
    read_index = 1'b1;
    row(0, 1'b1, 290, 1110, 1'b1);
    full_row(38);
    full_row(40);
    full_row(80);
    row(100, 1'b0, 290, 1110, 1'b0);
    full_row(120);
    full_row(122);
    full_row(200);
    full_row(204);
    read_index = 1'b0;
    full_row(300);
    full_row(400);
    full_row(511);
    full_row(512);
    full_row(513);
    full_row(700);

    row(0, 1'b1, 290, 1110, 1'b0);
    full_row(64);
    row(300, 1'b1, 290, 700, 1'b0);
    hit_reset();
    full_row(302);
    full_row(400);
    read_index = 1'b1;
    full_row(0);
    full_row(200);
    full_row(512);
    repeat (2) step(0, 600, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
